// File: rtl/rob_pkg.sv
// Shared constants and helpers for the reorder-buffer controller.
package rob_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_DRAINING = 2'd1;
  localparam logic [1:0] ST_DRAINED  = 2'd2;

  function automatic int unsigned rob_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // True when addr lies in the occupied window [head, head+count) modulo depth.
  function automatic logic in_window(input int unsigned head, input int unsigned count,
                                     input int unsigned addr, input int unsigned depth);
    return ((addr - head) & (depth - 32'd1)) < count;
  endfunction

endpackage

// File: rtl/rob_entry_done.sv
// One ROB entry's done bit; set by any matching writeback lane, cleared on alloc/commit/flush.
module rob_entry_done #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned IDX        = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [NUM_LANES-1:0]                 wb_set,
  input  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] wb_addr,
  input  logic                                 alloc_clr,
  input  logic                                 commit_clr,
  output logic                                 done
);

  logic done_q;
  logic done_d;
  logic hit;

  always_comb begin
    hit = 1'b0;
    for (int unsigned p = 0; p < NUM_LANES; p++) begin
      if (wb_set[p] && (wb_addr[p] == ADDR_WIDTH'(IDX))) hit = 1'b1;
    end
    done_d = done_q;
    if (hit) done_d = 1'b1;
    // Clearing has priority so a stale writeback cannot mark a fresh entry done.
    if (alloc_clr || commit_clr || flush) done_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= done_d;
  end

  assign done = done_q;

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer pointer/occupancy/commit sequencer with drain handshake and flush.
// Define ROB_CTRL_STATS_EN to add commit_cnt / stall_cnt statistics outputs.
module rob_ctrl
  import rob_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 3,
  parameter int unsigned LOG_PORT_NUM = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alloc_req,
  output logic                  alloc_ok,
  output logic [ADDR_WIDTH-1:0] alloc_idx,
  input  logic                  wb_we_a,
  input  logic                  wb_we_b,
  input  logic                  wb_we_c,
  input  logic [ADDR_WIDTH-1:0] wb_addr_a,
  input  logic [ADDR_WIDTH-1:0] wb_addr_b,
  input  logic [ADDR_WIDTH-1:0] wb_addr_c,
  output logic                  commit_valid,
  output logic [ADDR_WIDTH-1:0] commit_idx,
  input  logic                  flush,
  input  logic                  drain_req,
  output logic                  drain_done,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
`ifdef ROB_CTRL_STATS_EN
  ,
  output logic [31:0]           commit_cnt,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int unsigned DEPTH     = rob_depth(ADDR_WIDTH);
  localparam int unsigned WB_LANES  = 32'd1 << LOG_PORT_NUM;
  localparam int unsigned CNT_W     = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [1:0]            state_q, state_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  drain_done_q, drain_done_d;

  logic [DEPTH-1:0]                           done;
  logic [WB_LANES-1:0]                        wb_we_v, wb_set;
  logic [WB_LANES-1:0][ADDR_WIDTH-1:0]        wb_addr_v;

  // Writeback lanes beyond the three physical ports stay idle.
  always_comb begin
    wb_we_v      = '0;
    wb_addr_v    = '0;
    wb_we_v[0]   = wb_we_a;
    wb_we_v[1]   = wb_we_b;
    wb_we_v[2]   = wb_we_c;
    wb_addr_v[0] = wb_addr_a;
    wb_addr_v[1] = wb_addr_b;
    wb_addr_v[2] = wb_addr_c;
    for (int unsigned p = 0; p < WB_LANES; p++) begin
      wb_set[p] = wb_we_v[p] &&
                  in_window(32'(head_q), 32'(count_q), 32'(wb_addr_v[p]), DEPTH);
    end
  end

  assign alloc_ok     = alloc_req && !full_q && (state_q == ST_RUN) && !flush;
  assign commit_valid = !empty_q && done[head_q] && !flush;
  assign alloc_idx    = tail_q;
  assign commit_idx   = head_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    rob_entry_done #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_LANES  (WB_LANES),
      .IDX        (i)
    ) u_done (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .wb_set     (wb_set),
      .wb_addr    (wb_addr_v),
      .alloc_clr  (alloc_ok && (tail_q == ADDR_WIDTH'(i))),
      .commit_clr (commit_valid && (head_q == ADDR_WIDTH'(i))),
      .done       (done[i])
    );
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    state_d = state_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      state_d = ((state_q != ST_RUN) && drain_req) ? ST_DRAINED : ST_RUN;
    end else begin
      if (alloc_ok)     tail_d = tail_q + ADDR_WIDTH'(1);
      if (commit_valid) head_d = head_q + ADDR_WIDTH'(1);
      count_d = count_q + CNT_W'(alloc_ok) - CNT_W'(commit_valid);
      case (state_q)
        ST_RUN:      if (drain_req) state_d = ST_DRAINING;
        ST_DRAINING: begin
          if (drain_req && (count_d == '0)) state_d = ST_DRAINED;
          else if (!drain_req)              state_d = ST_RUN;
        end
        ST_DRAINED:  if (!drain_req) state_d = ST_RUN;
        default:     state_d = ST_RUN;
      endcase
    end
    full_d       = (count_d == CNT_W'(DEPTH));
    empty_d      = (count_d == '0);
    drain_done_d = (state_d == ST_DRAINED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      state_q      <= ST_RUN;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      drain_done_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      state_q      <= state_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      drain_done_q <= drain_done_d;
    end
  end

  assign full       = full_q;
  assign empty      = empty_q;
  assign count      = count_q;
  assign drain_done = drain_done_q;

`ifdef ROB_CTRL_STATS_EN
  logic [31:0] commit_cnt_q, commit_cnt_d, stall_cnt_q, stall_cnt_d;

  // Statistics survive flush; only reset clears them.
  always_comb begin
    commit_cnt_d = commit_cnt_q + 32'(commit_valid);
    stall_cnt_d  = stall_cnt_q + 32'(alloc_req && !alloc_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      commit_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      commit_cnt_q <= commit_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign commit_cnt = commit_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed self-checking bench for rob_ctrl; inputs change just after posedge, checks at negedge.
module tb_rob_ctrl;

  logic       clk = 1'b0;
  logic       reset, alloc_req, alloc_ok;
  logic [2:0] alloc_idx, commit_idx;
  logic       wb_we_a, wb_we_b, wb_we_c;
  logic [2:0] wb_addr_a, wb_addr_b, wb_addr_c;
  logic       commit_valid, flush, drain_req, drain_done, full, empty;
  logic [3:0] count;
`ifdef ROB_CTRL_STATS_EN
  logic [31:0] commit_cnt, stall_cnt;
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  rob_ctrl #(.ADDR_WIDTH(3), .LOG_PORT_NUM(2)) dut (
    .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_ok(alloc_ok),
    .alloc_idx(alloc_idx), .wb_we_a(wb_we_a), .wb_we_b(wb_we_b), .wb_we_c(wb_we_c),
    .wb_addr_a(wb_addr_a), .wb_addr_b(wb_addr_b), .wb_addr_c(wb_addr_c),
    .commit_valid(commit_valid), .commit_idx(commit_idx), .flush(flush),
    .drain_req(drain_req), .drain_done(drain_done), .full(full), .empty(empty),
    .count(count)
`ifdef ROB_CTRL_STATS_EN
    , .commit_cnt(commit_cnt), .stall_cnt(stall_cnt)
`endif
  );

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    alloc_req = 0; flush = 0; drain_req = 0;
    wb_we_a = 0; wb_we_b = 0; wb_we_c = 0;
    wb_addr_a = 0; wb_addr_b = 0; wb_addr_c = 0;
  endtask

  task automatic do_reset();
    clear_inputs(); reset = 1; cycle(); cycle(); reset = 0;
  endtask

  task automatic alloc_n(input int n);
    alloc_req = 1; repeat (n) cycle(); alloc_req = 0;
  endtask

  task automatic test_reset();
    do_reset(); @(negedge clk);
    cmp_cnt++; if (count !== 4'd0) begin err_cnt++; $display("FAIL reset_count got=%0d exp=0", count); end
    cmp_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL reset_empty got=%b exp=1", empty); end
    cmp_cnt++; if (full !== 1'b0) begin err_cnt++; $display("FAIL reset_full got=%b exp=0", full); end
    cmp_cnt++; if (alloc_ok !== 1'b0) begin err_cnt++; $display("FAIL reset_alloc_ok got=%b exp=0", alloc_ok); end
    cmp_cnt++; if (commit_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_commit got=%b exp=0", commit_valid); end
    cmp_cnt++; if (drain_done !== 1'b0) begin err_cnt++; $display("FAIL reset_drain_done got=%b exp=0", drain_done); end
    cmp_cnt++; if (alloc_idx !== 3'd0 || commit_idx !== 3'd0) begin err_cnt++; $display("FAIL reset_ptrs got=%0d/%0d exp=0/0", alloc_idx, commit_idx); end
    cycle();
  endtask

  task automatic test_fill();
    do_reset();
    alloc_req = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cmp_cnt++; if (alloc_ok !== 1'b1) begin err_cnt++; $display("FAIL fill_ok[%0d] got=%b exp=1", i, alloc_ok); end
      cmp_cnt++; if (alloc_idx !== 3'(i)) begin err_cnt++; $display("FAIL fill_idx[%0d] got=%0d exp=%0d", i, alloc_idx, i); end
      cycle();
    end
    @(negedge clk);
    cmp_cnt++; if (full !== 1'b1) begin err_cnt++; $display("FAIL fill_full got=%b exp=1", full); end
    cmp_cnt++; if (alloc_ok !== 1'b0) begin err_cnt++; $display("FAIL fill_9th_ok got=%b exp=0", alloc_ok); end
    cmp_cnt++; if (count !== 4'd8) begin err_cnt++; $display("FAIL fill_count got=%0d exp=8", count); end
    cycle();
  endtask

  // Continues from the full ROB left by test_fill.
  task automatic test_full_commit();
    alloc_req = 1; wb_we_a = 1; wb_addr_a = 3'd0;
    @(negedge clk);
    cmp_cnt++; if (commit_valid !== 1'b0) begin err_cnt++; $display("FAIL fc_early_commit got=%b exp=0", commit_valid); end
    cycle(); wb_we_a = 0;
    @(negedge clk);
    cmp_cnt++; if (commit_valid !== 1'b1 || commit_idx !== 3'd0) begin err_cnt++; $display("FAIL fc_commit got=%b/%0d exp=1/0", commit_valid, commit_idx); end
    cmp_cnt++; if (alloc_ok !== 1'b0) begin err_cnt++; $display("FAIL fc_alloc_blocked got=%b exp=0", alloc_ok); end
    cycle();
    @(negedge clk);
    cmp_cnt++; if (count !== 4'd7 || full !== 1'b0) begin err_cnt++; $display("FAIL fc_count got=%0d/%b exp=7/0", count, full); end
    cmp_cnt++; if (alloc_ok !== 1'b1 || alloc_idx !== 3'd0) begin err_cnt++; $display("FAIL fc_wrap_alloc got=%b/%0d exp=1/0", alloc_ok, alloc_idx); end
    cycle(); alloc_req = 0;
    @(negedge clk);
    cmp_cnt++; if (count !== 4'd8 || full !== 1'b1) begin err_cnt++; $display("FAIL fc_refull got=%0d/%b exp=8/1", count, full); end
    cycle();
  endtask

  task automatic test_out_of_order();
    do_reset(); alloc_n(3);
    wb_we_c = 1; wb_addr_c = 3'd2;
    @(negedge clk);
    cmp_cnt++; if (commit_valid !== 1'b0) begin err_cnt++; $display("FAIL ooo_c2 got=%b exp=0", commit_valid); end
    cycle(); wb_we_c = 0; wb_we_a = 1; wb_addr_a = 3'd0;
    @(negedge clk);
    cmp_cnt++; if (commit_valid !== 1'b0) begin err_cnt++; $display("FAIL ooo_no_idx2_first got=%b exp=0", commit_valid); end
    cycle(); wb_we_a = 0; wb_we_b = 1; wb_addr_b = 3'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp_cnt++; if (commit_valid !== 1'b1 || commit_idx !== 3'(i)) begin err_cnt++; $display("FAIL ooo_commit[%0d] got=%b/%0d exp=1/%0d", i, commit_valid, commit_idx, i); end
      cycle(); wb_we_b = 0;
    end
    @(negedge clk);
    cmp_cnt++; if (empty !== 1'b1 || count !== 4'd0 || commit_valid !== 1'b0) begin err_cnt++; $display("FAIL ooo_empty got=%b/%0d/%b exp=1/0/0", empty, count, commit_valid); end
    cycle();
  endtask

  task automatic test_window();
    do_reset(); alloc_n(6);
    wb_we_a = 1; wb_addr_a = 3'd0; wb_we_b = 1; wb_addr_b = 3'd1; wb_we_c = 1; wb_addr_c = 3'd2;
    cycle(); clear_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp_cnt++; if (commit_valid !== 1'b1 || commit_idx !== 3'(i)) begin err_cnt++; $display("FAIL win_pre[%0d] got=%b/%0d exp=1/%0d", i, commit_valid, commit_idx, i); end
      cycle();
    end
    // window is now [3,6)
    wb_we_a = 1; wb_we_b = 1; wb_we_c = 1; wb_addr_a = 3'd4; wb_addr_b = 3'd4; wb_addr_c = 3'd4;
    @(negedge clk);
    cmp_cnt++; if (commit_valid !== 1'b0 || count !== 4'd3) begin err_cnt++; $display("FAIL win_head3_wait got=%b/%0d exp=0/3", commit_valid, count); end
    cycle(); clear_inputs();
    wb_we_a = 1; wb_addr_a = 3'd7; wb_we_b = 1; wb_addr_b = 3'd3;
    cycle(); clear_inputs();
    @(negedge clk);
    cmp_cnt++; if (commit_valid !== 1'b1 || commit_idx !== 3'd3) begin err_cnt++; $display("FAIL win_commit3 got=%b/%0d exp=1/3", commit_valid, commit_idx); end
    cycle(); @(negedge clk);
    cmp_cnt++; if (commit_valid !== 1'b1 || commit_idx !== 3'd4) begin err_cnt++; $display("FAIL win_commit4 got=%b/%0d exp=1/4", commit_valid, commit_idx); end
    cycle(); @(negedge clk);
    cmp_cnt++; if (commit_valid !== 1'b0 || count !== 4'd1) begin err_cnt++; $display("FAIL win_idx5_pending got=%b/%0d exp=0/1", commit_valid, count); end
    wb_we_c = 1; wb_addr_c = 3'd5;
    cycle(); clear_inputs(); cycle();
    alloc_req = 1; @(negedge clk);
    cmp_cnt++; if (alloc_idx !== 3'd6 || empty !== 1'b1) begin err_cnt++; $display("FAIL win_tail6 got=%0d/%b exp=6/1", alloc_idx, empty); end
    cycle(); cycle(); alloc_req = 0;
    wb_we_a = 1; wb_addr_a = 3'd6;
    cycle(); clear_inputs(); @(negedge clk);
    cmp_cnt++; if (commit_valid !== 1'b1 || commit_idx !== 3'd6) begin err_cnt++; $display("FAIL win_commit6 got=%b/%0d exp=1/6", commit_valid, commit_idx); end
    cycle(); @(negedge clk);
    cmp_cnt++; if (commit_valid !== 1'b0 || commit_idx !== 3'd7 || count !== 4'd1) begin err_cnt++; $display("FAIL win_stale7 got=%b/%0d/%0d exp=0/7/1", commit_valid, commit_idx, count); end
    cycle();
  endtask

  task automatic test_drain();
    do_reset(); alloc_n(2);
    drain_req = 1; cycle();
    alloc_req = 1; @(negedge clk);
    cmp_cnt++; if (alloc_ok !== 1'b0 || drain_done !== 1'b0) begin err_cnt++; $display("FAIL drain_block got=%b/%b exp=0/0", alloc_ok, drain_done); end
    wb_we_a = 1; wb_addr_a = 3'd0; wb_we_b = 1; wb_addr_b = 3'd1;
    cycle(); wb_we_a = 0; wb_we_b = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cmp_cnt++; if (commit_valid !== 1'b1 || commit_idx !== 3'(i) || drain_done !== 1'b0) begin err_cnt++; $display("FAIL drain_commit[%0d] got=%b/%0d/%b exp=1/%0d/0", i, commit_valid, commit_idx, drain_done, i); end
      cycle();
    end
    @(negedge clk);
    cmp_cnt++; if (drain_done !== 1'b1 || empty !== 1'b1 || alloc_ok !== 1'b0) begin err_cnt++; $display("FAIL drain_done got=%b/%b/%b exp=1/1/0", drain_done, empty, alloc_ok); end
    cycle(); drain_req = 0; alloc_req = 0;
    @(negedge clk);
    cmp_cnt++; if (drain_done !== 1'b1) begin err_cnt++; $display("FAIL drain_hold got=%b exp=1", drain_done); end
    cycle(); alloc_req = 1; @(negedge clk);
    cmp_cnt++; if (drain_done !== 1'b0 || alloc_ok !== 1'b1 || alloc_idx !== 3'd2) begin err_cnt++; $display("FAIL drain_resume got=%b/%b/%0d exp=0/1/2", drain_done, alloc_ok, alloc_idx); end
    cycle(); alloc_req = 0;
    // drain request withdrawn before the ROB empties
    drain_req = 1; cycle();
    drain_req = 0; alloc_req = 1; @(negedge clk);
    cmp_cnt++; if (alloc_ok !== 1'b0) begin err_cnt++; $display("FAIL drain_abort_block got=%b exp=0", alloc_ok); end
    cycle(); @(negedge clk);
    cmp_cnt++; if (alloc_ok !== 1'b1 || alloc_idx !== 3'd3 || count !== 4'd1 || drain_done !== 1'b0) begin err_cnt++; $display("FAIL drain_abort_run got=%b/%0d/%0d/%b exp=1/3/1/0", alloc_ok, alloc_idx, count, drain_done); end
    cycle(); clear_inputs();
  endtask

  task automatic test_flush();
    do_reset(); alloc_n(5);
    wb_we_a = 1; wb_addr_a = 3'd0; wb_we_b = 1; wb_addr_b = 3'd3;
    cycle(); clear_inputs();
    flush = 1; alloc_req = 1; @(negedge clk);
    cmp_cnt++; if (commit_valid !== 1'b0 || alloc_ok !== 1'b0) begin err_cnt++; $display("FAIL flush_gate got=%b/%b exp=0/0", commit_valid, alloc_ok); end
    cycle(); clear_inputs(); @(negedge clk);
    cmp_cnt++; if (count !== 4'd0 || empty !== 1'b1 || commit_valid !== 1'b0 || alloc_idx !== 3'd0 || commit_idx !== 3'd0) begin err_cnt++; $display("FAIL flush_state got=%0d/%b/%b/%0d/%0d exp=0/1/0/0/0", count, empty, commit_valid, alloc_idx, commit_idx); end
    cycle();
    alloc_n(2); drain_req = 1; cycle();
    flush = 1; cycle(); flush = 0; @(negedge clk);
    cmp_cnt++; if (drain_done !== 1'b1 || count !== 4'd0) begin err_cnt++; $display("FAIL flush_drained got=%b/%0d exp=1/0", drain_done, count); end
    drain_req = 0; cycle(); @(negedge clk);
    cmp_cnt++; if (drain_done !== 1'b0) begin err_cnt++; $display("FAIL flush_drain_exit got=%b exp=0", drain_done); end
    cycle();
  endtask

  task automatic test_reset_mid();
    do_reset(); alloc_n(5);
    wb_we_a = 1; wb_addr_a = 3'd0; wb_we_b = 1; wb_addr_b = 3'd3;
    cycle(); clear_inputs();
    reset = 1; alloc_req = 1; cycle(); reset = 0; alloc_req = 0; @(negedge clk);
    cmp_cnt++; if (count !== 4'd0 || empty !== 1'b1 || commit_valid !== 1'b0 || alloc_idx !== 3'd0 || commit_idx !== 3'd0) begin err_cnt++; $display("FAIL rstmid_state got=%0d/%b/%b/%0d/%0d exp=0/1/0/0/0", count, empty, commit_valid, alloc_idx, commit_idx); end
    cycle();
  endtask

  initial begin
    clear_inputs(); reset = 1;
    test_reset();
    test_fill();
    test_full_commit();
    test_out_of_order();
    test_window();
    test_drain();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
